flexbex_ibex_fetch_aligner: RTL and testbench
=============================================

// Module: flexbex_ibex_fetch_aligner
// PURPOSE
//   Sits between the prefetch buffer and the compressed decoder. Takes 32-bit
//   word-aligned fetch words and emits one instruction per handshake, 16-bit
//   or 32-bit. The instruction may straddle two fetch words or start on a
//   halfword-aligned branch target. Tracks the PC of the emitted instruction.
// PARAMETERS
//   RESET_PC  32'h0000_0080  PC loaded at reset; bit 0 is ignored
// PORTS
//   clk_i                  in   1   clock
//   rst_i                  in   1   synchronous, active-high reset
//   flush_i                in   1   redirect: drop all held state
//   flush_addr_i           in   32  redirect target, halfword aligned; bit 0 ignored
//   fetch_valid_i          in   1   fetch word valid
//   fetch_ready_o          out  1   fetch word consumed this cycle
//   fetch_rdata_i          in   32  fetch word, little-endian halfwords
//   instr_valid_o          out  1   aligned instruction valid
//   instr_ready_i          in   1   decoder accepts instruction
//   instr_rdata_o          out  32  instruction; compressed form is {16'h0,hw}
//   instr_addr_o           out  32  PC of instr_rdata_o
//   instr_is_compressed_o  out  1   instr_rdata_o[1:0] != 2'b11
// BEHAVIOUR
//   State: state_q in {ALIGNED, RESID, SKIP}, resid_q[15:0], pc_q[31:1].
//   Reset: state_q=ALIGNED, resid_q=0, pc_q=RESET_PC[31:1].
//     While rst_i=1: instr_valid_o=0 and fetch_ready_o=0.
//   Outputs are combinational from state and inputs; zero-cycle latency.
//     instr_addr_o = {pc_q,1'b0}.
//   Emission fires when instr_valid_o & instr_ready_i. F = fetch_rdata_i.
//   ALIGNED
//     valid = fetch_valid_i.
//     F[1:0]!=11: out={16'h0,F[15:0]}. On fire: consume F, resid_q<=F[31:16],
//       go RESID, pc+=2.
//     F[1:0]==11: out=F. On fire: consume F, pc+=4.
//   RESID
//     resid_q[1:0]!=11: valid=1, out={16'h0,resid_q}, fetch_ready_o=0.
//       On fire: go ALIGNED, pc+=2.
//     resid_q[1:0]==11: valid=fetch_valid_i, out={F[15:0],resid_q}.
//       On fire: consume F, resid_q<=F[31:16], stay RESID, pc+=4.
//   SKIP (entered by flush to addr[1]=1; F[15:0] is discarded)
//     F[17:16]!=11: valid=fetch_valid_i, out={16'h0,F[31:16]}.
//       On fire: consume F, go ALIGNED, pc+=2.
//     F[17:16]==11: valid=0, fetch_ready_o=fetch_valid_i.
//       On consume: resid_q<=F[31:16], go RESID; pc unchanged.
//   fetch_ready_o=1 only when a word is consumed per the rules above.
//     It never asserts without fetch_valid_i.
//   Backpressure: instr_ready_i=0 means no consume and no state/pc change.
//     Outputs stay stable while fetch inputs are stable.
//   Flush (priority over all but reset): instr_valid_o=0, fetch_ready_o=0
//     that cycle. Next: pc_q<=flush_addr_i[31:1], resid_q dropped;
//     state<= flush_addr_i[1] ? SKIP : ALIGNED.
//   pc wraps modulo 2^32. Reset mid-operation discards resid_q immediately.
// TESTING
//   1 Reset, word 0x0141_4501 -> 0x00004501@0x80 (compressed);
//     next cycle 0x00000141@0x82 with fetch_ready_o=0; then ALIGNED, pc=0x84.
//   2 Words 0x0513_4501, 0xABCD_0005 -> 0x00004501@0x80, 0x00050513@0x82;
//     resid_q=0xABCD, pc=0x86.
//   3 flush_addr=0x102, word 0x4501_FFFF -> 0x00004501@0x102, low half
//     dropped; word 0x0513_FFFF then 0x0000_0005 -> 0x00050513@0x102.
//   4 flush_i while RESID holds 0x0513 -> no emission that cycle;
//     next instr at flush addr, no trace of 0x0513.
//   5 instr_ready_i=0 for 3 cycles mid-straddle -> instr_rdata_o, addr,
//     fetch_ready_o=0 all stable; release emits once, pc+=4.
//   6 rst_i asserted in RESID -> next cycle ALIGNED, pc=0x80,
//     instr_valid_o=0 during reset.

Source files
------------

// File: rtl/flexbex_ibex_fetch_aligner.sv
// Fetch aligner: turns 32-bit word-aligned fetch words into a stream of
// 16-bit (compressed) and 32-bit instructions. Instructions may straddle two
// fetch words or start on a halfword-aligned redirect target. The PC of the
// instruction currently presented is tracked alongside.
//
// Handshakes (both sides): a transfer happens in a cycle where valid and
// ready are both high. instr_valid_o/instr_rdata_o/instr_addr_o do not wait
// on instr_ready_i. fetch_ready_o is an acknowledge: it is high only in a
// cycle where the presented fetch word is actually consumed, so it never
// asserts without fetch_valid_i.
module flexbex_ibex_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0080
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_addr_o,
    output logic        instr_is_compressed_o
);

    // ALIGNED: next instruction starts at bit 0 of the fetch word.
    // RESID:   next instruction starts in the held upper halfword resid_q.
    // SKIP:    next instruction starts at bit 16 of the fetch word.
    typedef enum logic [1:0] {
        ALIGNED = 2'd0,
        RESID   = 2'd1,
        SKIP    = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] resid_q, resid_d;
    logic [31:1] pc_q, pc_d;

    logic        valid;
    logic        fire;

    // State, residual halfword and PC registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ALIGNED;
            resid_q <= 16'h0000;
            pc_q    <= RESET_PC[31:1];
        end else begin
            state_q <= state_d;
            resid_q <= resid_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state logic and combinational outputs.
    always_comb begin
        state_d       = state_q;
        resid_d       = resid_q;
        pc_d          = pc_q;
        valid         = 1'b0;
        fetch_ready_o = 1'b0;
        instr_rdata_o = 32'h0000_0000;
        fire          = 1'b0;

        if (rst_i) begin
            // Hold everything quiet; the register block reloads reset values.
            valid         = 1'b0;
            fetch_ready_o = 1'b0;
        end else if (flush_i) begin
            // Redirect wins over any emission this cycle.
            valid   = 1'b0;
            resid_d = 16'h0000;
            pc_d    = flush_addr_i[31:1];
            state_d = flush_addr_i[1] ? SKIP : ALIGNED;
        end else begin
            unique case (state_q)
                ALIGNED: begin
                    valid = fetch_valid_i;
                    fire  = valid & instr_ready_i;
                    if (fetch_rdata_i[1:0] != 2'b11) begin
                        instr_rdata_o = {16'h0000, fetch_rdata_i[15:0]};
                        if (fire) begin
                            fetch_ready_o = 1'b1;
                            resid_d       = fetch_rdata_i[31:16];
                            state_d       = RESID;
                            pc_d          = pc_q + 31'd1;
                        end
                    end else begin
                        instr_rdata_o = fetch_rdata_i;
                        if (fire) begin
                            fetch_ready_o = 1'b1;
                            pc_d          = pc_q + 31'd2;
                        end
                    end
                end
                RESID: begin
                    if (resid_q[1:0] != 2'b11) begin
                        // Held compressed instruction; no fetch word needed.
                        valid         = 1'b1;
                        fire          = instr_ready_i;
                        instr_rdata_o = {16'h0000, resid_q};
                        if (fire) begin
                            state_d = ALIGNED;
                            pc_d    = pc_q + 31'd1;
                        end
                    end else begin
                        // Straddling 32-bit instruction: upper half from F.
                        valid         = fetch_valid_i;
                        fire          = valid & instr_ready_i;
                        instr_rdata_o = {fetch_rdata_i[15:0], resid_q};
                        if (fire) begin
                            fetch_ready_o = 1'b1;
                            resid_d       = fetch_rdata_i[31:16];
                            pc_d          = pc_q + 31'd2;
                        end
                    end
                end
                SKIP: begin
                    if (fetch_rdata_i[17:16] != 2'b11) begin
                        valid         = fetch_valid_i;
                        fire          = valid & instr_ready_i;
                        instr_rdata_o = {16'h0000, fetch_rdata_i[31:16]};
                        if (fire) begin
                            fetch_ready_o = 1'b1;
                            state_d       = ALIGNED;
                            pc_d          = pc_q + 31'd1;
                        end
                    end else begin
                        // Only the first half of a 32-bit instruction: park it.
                        valid         = 1'b0;
                        fetch_ready_o = fetch_valid_i;
                        if (fetch_valid_i) begin
                            resid_d = fetch_rdata_i[31:16];
                            state_d = RESID;
                        end
                    end
                end
                default: begin
                    state_d = ALIGNED;
                end
            endcase
        end
    end

    assign instr_valid_o         = valid;
    assign instr_addr_o          = {pc_q, 1'b0};
    assign instr_is_compressed_o = (instr_rdata_o[1:0] != 2'b11);

endmodule

// File: tb/tb_flexbex_ibex_fetch_aligner.sv
// Directed bench for the fetch aligner: per-cycle output checks plus an
// expected-instruction queue drained on every emission handshake.
module tb_flexbex_ibex_fetch_aligner;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic [31:0] flush_addr_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_addr_o;
  logic        instr_is_compressed_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  flexbex_ibex_fetch_aligner #(.RESET_PC(32'h0000_0080)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .flush_i               (flush_i),
    .flush_addr_i          (flush_addr_i),
    .fetch_valid_i         (fetch_valid_i),
    .fetch_ready_o         (fetch_ready_o),
    .fetch_rdata_i         (fetch_rdata_i),
    .instr_valid_o         (instr_valid_o),
    .instr_ready_i         (instr_ready_i),
    .instr_rdata_o         (instr_rdata_o),
    .instr_addr_o          (instr_addr_o),
    .instr_is_compressed_o (instr_is_compressed_o)
  );

  // clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic v, input logic [31:0] rd,
                     input logic [31:0] ad, input logic fr);
    check({tag, ".valid"}, {31'd0, instr_valid_o}, {31'd0, v});
    if (v) begin
      check({tag, ".rdata"}, instr_rdata_o, rd);
      check({tag, ".comp"}, {31'd0, instr_is_compressed_o}, {31'd0, rd[1:0] != 2'b11});
    end
    check({tag, ".addr"}, instr_addr_o, ad);
    check({tag, ".fready"}, {31'd0, fetch_ready_o}, {31'd0, fr});
  endtask

  // scoreboard: every emission handshake must match the next expected entry
  always @(negedge clk_i) begin
    if (!rst_i && instr_valid_o && instr_ready_i) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", instr_rdata_o, 32'hxxxx_xxxx);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("sb_addr", instr_addr_o, e[63:32]);
        check("sb_data", instr_rdata_o, e[31:0]);
      end
    end
  end

  // driver tasks
  task automatic push(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic drive(input logic fv, input logic [31:0] f, input logic ir);
    fetch_valid_i = fv;
    fetch_rdata_i = f;
    instr_ready_i = ir;
  endtask

  task automatic sample;
    @(negedge clk_i);
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_i   = 1'b1;
    flush_i = 1'b0;
    drive(1'b1, 32'h0141_4501, 1'b1);
    sample;
    check({tag, ".rst_valid"}, {31'd0, instr_valid_o}, 32'd0);
    check({tag, ".rst_fready"}, {31'd0, fetch_ready_o}, 32'd0);
    tick;
    rst_i = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
  endtask

  // stimulus
  initial begin
    rst_i = 1'b1;
    flush_i = 1'b0;
    flush_addr_i = 32'h0;
    drive(1'b0, 32'h0, 1'b1);
    tick;

    // 1: compressed pair from one word
    do_reset("t1");
    push(32'h80, 32'h0000_4501);
    drive(1'b1, 32'h0141_4501, 1'b1); sample; chk("t1a", 1'b1, 32'h4501, 32'h80, 1'b1); tick;
    push(32'h82, 32'h0000_0141);
    drive(1'b0, 32'h0, 1'b1); sample; chk("t1b", 1'b1, 32'h0141, 32'h82, 1'b0); tick;
    drive(1'b0, 32'h0, 1'b1); sample; chk("t1c", 1'b0, 32'h0, 32'h84, 1'b0); tick;

    // 2: straddling 32-bit instruction
    do_reset("t2");
    push(32'h80, 32'h0000_4501);
    drive(1'b1, 32'h0513_4501, 1'b1); sample; chk("t2a", 1'b1, 32'h4501, 32'h80, 1'b1); tick;
    push(32'h82, 32'h0005_0513);
    drive(1'b1, 32'hABCD_0005, 1'b1); sample; chk("t2b", 1'b1, 32'h0005_0513, 32'h82, 1'b1); tick;
    drive(1'b0, 32'h0, 1'b0); sample; chk("t2c", 1'b1, 32'hABCD, 32'h86, 1'b0); tick;

    // 6: reset while in RESID
    rst_i = 1'b1;
    drive(1'b0, 32'h0, 1'b1); sample; chk("t6a", 1'b0, 32'h0, 32'h86, 1'b0); tick;
    rst_i = 1'b0;
    drive(1'b0, 32'h0, 1'b1); sample; chk("t6b", 1'b0, 32'h0, 32'h80, 1'b0); tick;
    push(32'h80, 32'h0000_2221);
    drive(1'b1, 32'h1111_2221, 1'b1); sample; chk("t6c", 1'b1, 32'h2221, 32'h80, 1'b1); tick;

    // 3: flush to odd halfword, compressed then straddling
    flush_i = 1'b1; flush_addr_i = 32'h102;
    drive(1'b1, 32'hFFFF_FFFF, 1'b1); sample; chk("t3a", 1'b0, 32'h0, 32'h82, 1'b0); tick;
    flush_i = 1'b0;
    push(32'h102, 32'h0000_4501);
    drive(1'b1, 32'h4501_FFFF, 1'b1); sample; chk("t3b", 1'b1, 32'h4501, 32'h102, 1'b1); tick;
    drive(1'b0, 32'h0, 1'b1); sample; chk("t3c", 1'b0, 32'h0, 32'h104, 1'b0); tick;
    flush_i = 1'b1; flush_addr_i = 32'h102;
    drive(1'b0, 32'h0, 1'b1); sample; chk("t3d", 1'b0, 32'h0, 32'h104, 1'b0); tick;
    flush_i = 1'b0;
    drive(1'b1, 32'h0513_FFFF, 1'b1); sample; chk("t3e", 1'b0, 32'h0, 32'h102, 1'b1); tick;
    push(32'h102, 32'h0005_0513);
    drive(1'b1, 32'h0000_0005, 1'b1); sample; chk("t3f", 1'b1, 32'h0005_0513, 32'h102, 1'b1); tick;
    drive(1'b0, 32'h0, 1'b0); sample; chk("t3g", 1'b1, 32'h0000, 32'h106, 1'b0); tick;

    // 4: flush drops a held residual
    do_reset("t4");
    push(32'h80, 32'h0000_4501);
    drive(1'b1, 32'h0513_4501, 1'b1); sample; chk("t4a", 1'b1, 32'h4501, 32'h80, 1'b1); tick;
    flush_i = 1'b1; flush_addr_i = 32'h200;
    drive(1'b1, 32'hABCD_0005, 1'b1); sample; chk("t4b", 1'b0, 32'h0, 32'h82, 1'b0); tick;
    flush_i = 1'b0;
    push(32'h200, 32'h0000_4511);
    drive(1'b1, 32'h0000_4511, 1'b1); sample; chk("t4c", 1'b1, 32'h4511, 32'h200, 1'b1); tick;

    // 5: backpressure mid-straddle
    do_reset("t5");
    push(32'h80, 32'h0000_4501);
    drive(1'b1, 32'h0513_4501, 1'b1); sample; chk("t5a", 1'b1, 32'h4501, 32'h80, 1'b1); tick;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hABCD_0005, 1'b0); sample;
      chk("t5_hold", 1'b1, 32'h0005_0513, 32'h82, 1'b0); tick;
    end
    push(32'h82, 32'h0005_0513);
    drive(1'b1, 32'hABCD_0005, 1'b1); sample; chk("t5_rel", 1'b1, 32'h0005_0513, 32'h82, 1'b1); tick;
    drive(1'b0, 32'h0, 1'b0); sample; chk("t5_after", 1'b1, 32'hABCD, 32'h86, 1'b0); tick;

    // 7: aligned 32-bit instruction (flush addr bit 0 ignored), then pc wrap
    flush_i = 1'b1; flush_addr_i = 32'h301;
    drive(1'b0, 32'h0, 1'b1); sample; chk("t7a", 1'b0, 32'h0, 32'h86, 1'b0); tick;
    flush_i = 1'b0;
    push(32'h300, 32'h0050_0513);
    drive(1'b1, 32'h0050_0513, 1'b1); sample; chk("t7b", 1'b1, 32'h0050_0513, 32'h300, 1'b1); tick;
    drive(1'b0, 32'h0, 1'b1); sample; chk("t7c", 1'b0, 32'h0, 32'h304, 1'b0); tick;
    flush_i = 1'b1; flush_addr_i = 32'hFFFF_FFFE;
    drive(1'b0, 32'h0, 1'b1); sample; chk("t7d", 1'b0, 32'h0, 32'h304, 1'b0); tick;
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 1'b1); sample; chk("t7e", 1'b0, 32'h0, 32'hFFFF_FFFE, 1'b0); tick;
    push(32'hFFFF_FFFE, 32'h0000_0001);
    drive(1'b1, 32'h0001_1234, 1'b1); sample; chk("t7f", 1'b1, 32'h0001, 32'hFFFF_FFFE, 1'b1); tick;
    drive(1'b0, 32'h0, 1'b1); sample; chk("t7g", 1'b0, 32'h0, 32'h0000_0000, 1'b0); tick;

    // final report
    check("sb_left", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
